// File: rtl/bcd_sci_counter.sv
// BCD event counter with a scientific-notation display (mantissa digits, 'E', one exponent digit).
// The live count ripples on en; the display registers capture the post-increment mantissa/exponent.
module bcd_sci_counter #(
    parameter int DIGITS   = 11,
    parameter int MANT     = 2,
    parameter bit SATURATE = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  clr,
    input  logic                  freeze,
    output logic [4*DIGITS-1:0]   count_bcd,
    output logic [4*MANT-1:0]     mant_bcd,
    output logic [3:0]            exp_bcd,
    output logic                  ovf,
    output logic [7*(MANT+2)-1:0] sev_seg
);

    localparam logic [6:0]          BCD_E     = 7'h79;
    localparam logic [4*DIGITS-1:0] ALL_NINES = {DIGITS{4'h9}};

    logic [4*DIGITS-1:0] r_count;
    logic [4*MANT-1:0]   r_mant;
    logic [3:0]          r_exp;
    logic                r_ovf;

    logic [4*DIGITS-1:0] w_inc;
    logic [4*DIGITS-1:0] w_next;
    logic                w_all9;
    logic [3:0]          w_exp;
    logic [4*MANT-1:0]   w_mant;

    function automatic logic [6:0] seven_seg(input logic [3:0] d);
        case (d)
            4'd0:    seven_seg = 7'h3F;
            4'd1:    seven_seg = 7'h06;
            4'd2:    seven_seg = 7'h5B;
            4'd3:    seven_seg = 7'h4F;
            4'd4:    seven_seg = 7'h66;
            4'd5:    seven_seg = 7'h6D;
            4'd6:    seven_seg = 7'h7D;
            4'd7:    seven_seg = 7'h07;
            4'd8:    seven_seg = 7'h7F;
            4'd9:    seven_seg = 7'h6F;
            default: seven_seg = 7'h00;
        endcase
    endfunction

    // NOTE: w_inc takes a full default before the loop, so no latch is inferred.
    always_comb begin
        logic carry;
        carry = 1'b1;
        w_inc = r_count;
        for (int i = 0; i < DIGITS; i++) begin
            if (carry) begin
                if (r_count[4*i +: 4] == 4'd9) begin
                    w_inc[4*i +: 4] = 4'd0;
                end else begin
                    w_inc[4*i +: 4] = r_count[4*i +: 4] + 4'd1;
                    carry = 1'b0;
                end
            end
        end
    end

    assign w_all9 = (r_count == ALL_NINES);
    // In wrap mode the ripple already produces all zeros from all nines.
    assign w_next = (SATURATE && w_all9) ? r_count : w_inc;

    always_comb begin
        int msd;
        int e;
        msd = 0;
        for (int i = 0; i < DIGITS; i++) begin
            if (w_next[4*i +: 4] != 4'd0) begin
                msd = i;
            end
        end
        e      = (msd > MANT - 1) ? msd - (MANT - 1) : 0;
        w_exp  = 4'(e);
        w_mant = '0;
        for (int j = 0; j < MANT; j++) begin
            w_mant[4*j +: 4] = w_next[4*(e + j) +: 4];
        end
    end

    // NOTE: non-blocking assignments keep every register sampling pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
            r_ovf   <= 1'b0;
            r_mant  <= '0;
            r_exp   <= 4'd0;
        end else if (clr) begin
            r_count <= '0;
            r_ovf   <= 1'b0;
        end else if (en) begin
            r_count <= w_next;
            if (w_all9) begin
                r_ovf <= 1'b1;
            end
            if (!freeze) begin
                r_mant <= w_mant;
                r_exp  <= w_exp;
            end
        end
    end

    always_comb begin
        sev_seg        = '0;
        sev_seg[6:0]   = seven_seg(r_exp);
        sev_seg[13:7]  = BCD_E;
        for (int j = 0; j < MANT; j++) begin
            sev_seg[7*(j+2) +: 7] = seven_seg(r_mant[4*j +: 4]);
        end
    end

    assign count_bcd = r_count;
    assign mant_bcd  = r_mant;
    assign exp_bcd   = r_exp;
    assign ovf       = r_ovf;

endmodule

// File: tb/tb_bcd_sci_counter.sv
// Bench for bcd_sci_counter: three instances (11-digit wrap, 4-digit wrap, 4-digit saturate)
// share stimulus; an arithmetic reference model feeds a scoreboard drained by a monitor.
module tb_bcd_sci_counter;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic en = 1'b0;
    logic clr = 1'b0;
    logic freeze = 1'b0;

    always #5 clk = ~clk;

    logic [43:0] cnt_a;
    logic [15:0] cnt_b, cnt_c;
    logic [7:0]  mant_a, mant_b, mant_c;
    logic [3:0]  exp_a, exp_b, exp_c;
    logic        ovf_a, ovf_b, ovf_c;
    logic [27:0] seg_a, seg_b, seg_c;

    bcd_sci_counter #(.DIGITS(11), .MANT(2), .SATURATE(1'b0)) u_a (
        .clk(clk), .rst(rst), .en(en), .clr(clr), .freeze(freeze),
        .count_bcd(cnt_a), .mant_bcd(mant_a), .exp_bcd(exp_a), .ovf(ovf_a), .sev_seg(seg_a));
    bcd_sci_counter #(.DIGITS(4), .MANT(2), .SATURATE(1'b0)) u_b (
        .clk(clk), .rst(rst), .en(en), .clr(clr), .freeze(freeze),
        .count_bcd(cnt_b), .mant_bcd(mant_b), .exp_bcd(exp_b), .ovf(ovf_b), .sev_seg(seg_b));
    bcd_sci_counter #(.DIGITS(4), .MANT(2), .SATURATE(1'b1)) u_c (
        .clk(clk), .rst(rst), .en(en), .clr(clr), .freeze(freeze),
        .count_bcd(cnt_c), .mant_bcd(mant_c), .exp_bcd(exp_c), .ovf(ovf_c), .sev_seg(seg_c));

    typedef struct packed {
        logic [1:0]  inst;
        logic [63:0] cnt;
        logic [7:0]  mant;
        logic [3:0]  expo;
        logic        ovf;
        logic [27:0] seg;
    } exp_t;

    exp_t sb_q[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    const logic [6:0] SEG_TBL[10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                      7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
    const logic [6:0] SEG_E = 7'h79;
    const int P_DIG[3] = '{11, 4, 4};
    const bit P_SAT[3] = '{1'b0, 1'b0, 1'b1};

    longint     m_cnt[3];
    bit         m_ovf[3];
    logic [7:0] m_mant[3];
    logic [3:0] m_exp[3];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s @%0t: got %0h, expected %0h", name, $time, act, req);
        end
    endtask

    function automatic longint pow10(input int n);
        longint r = 1;
        for (int i = 0; i < n; i++) r = r * 10;
        return r;
    endfunction

    function automatic logic [63:0] to_bcd(input longint v);
        logic [63:0] r = '0;
        longint t = v;
        for (int i = 0; i < 16; i++) begin
            r[4*i +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    // Display value: leading MANT=2 significant digits, exponent = digits beyond them.
    task automatic model_display(input int i);
        int     nd = 0;
        int     ex;
        longint v  = m_cnt[i];
        longint man;
        while (v > 0) begin
            nd++;
            v = v / 10;
        end
        ex  = (nd > 2) ? nd - 2 : 0;
        man = (m_cnt[i] / pow10(ex)) % 100;
        m_mant[i] = {4'(man / 10), 4'(man % 10)};
        m_exp[i]  = 4'(ex);
    endtask

    task automatic model_edge(input bit r, input bit c, input bit e, input bit f);
        exp_t x;
        for (int i = 0; i < 3; i++) begin
            if (r) begin
                m_cnt[i] = 0; m_ovf[i] = 1'b0; m_mant[i] = 8'h00; m_exp[i] = 4'h0;
            end else if (c) begin
                m_cnt[i] = 0; m_ovf[i] = 1'b0;
            end else if (e) begin
                if (m_cnt[i] == pow10(P_DIG[i]) - 1) begin
                    m_ovf[i] = 1'b1;
                    if (!P_SAT[i]) m_cnt[i] = 0;
                end else begin
                    m_cnt[i] = m_cnt[i] + 1;
                end
                if (!f) model_display(i);
            end
            x.inst = 2'(i);
            x.cnt  = to_bcd(m_cnt[i]);
            x.mant = m_mant[i];
            x.expo = m_exp[i];
            x.ovf  = m_ovf[i];
            x.seg  = {SEG_TBL[m_mant[i][7:4]], SEG_TBL[m_mant[i][3:0]], SEG_E, SEG_TBL[m_exp[i]]};
            sb_q.push_back(x);
        end
    endtask

    // Monitor: registered outputs settle after each edge; compare on the falling edge.
    initial begin
        forever begin
            @(negedge clk);
            while (sb_q.size() > 0) begin
                exp_t        x;
                logic [63:0] a_cnt;
                logic [7:0]  a_mant;
                logic [3:0]  a_exp;
                logic        a_ovf;
                logic [27:0] a_seg;
                x = sb_q.pop_front();
                case (x.inst)
                    2'd0: begin a_cnt = 64'(cnt_a); a_mant = mant_a; a_exp = exp_a; a_ovf = ovf_a; a_seg = seg_a; end
                    2'd1: begin a_cnt = 64'(cnt_b); a_mant = mant_b; a_exp = exp_b; a_ovf = ovf_b; a_seg = seg_b; end
                    default: begin a_cnt = 64'(cnt_c); a_mant = mant_c; a_exp = exp_c; a_ovf = ovf_c; a_seg = seg_c; end
                endcase
                check($sformatf("u%0d.count", x.inst), a_cnt, x.cnt);
                check($sformatf("u%0d.mant", x.inst), 64'(a_mant), 64'(x.mant));
                check($sformatf("u%0d.exp", x.inst), 64'(a_exp), 64'(x.expo));
                check($sformatf("u%0d.ovf", x.inst), 64'(a_ovf), 64'(x.ovf));
                check($sformatf("u%0d.sev_seg", x.inst), 64'(a_seg), 64'(x.seg));
            end
        end
    end

    task automatic step(input bit r, input bit c, input bit e, input bit f);
        @(negedge clk);
        rst = r; clr = c; en = e; freeze = f;
        @(posedge clk);
        model_edge(r, c, e, f);
    endtask

    task automatic pulses(input int n, input bit f);
        for (int i = 0; i < n; i++) begin
            if ($urandom_range(0, 7) == 0) step(1'b0, 1'b0, 1'b0, 1'($urandom_range(0, 1)));
            step(1'b0, 1'b0, 1'b1, f);
        end
    endtask

    initial begin
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b1);
        #1;
        check("rst_cnt_a", 64'(cnt_a), 64'h0);
        check("rst_disp_a", 64'({mant_a, exp_a}), 64'h000);
        check("rst_ovf_c", 64'(ovf_c), 64'h0);

        pulses(99, 1'b0); #1;
        check("d99_cnt", 64'(cnt_a), 64'h99);
        check("d99_disp", 64'({mant_a, exp_a}), 64'h990);
        pulses(1, 1'b0); #1;
        check("d100_cnt", 64'(cnt_a), 64'h100);
        check("d100_disp", 64'({mant_a, exp_a}), 64'h101);
        pulses(1134, 1'b0); #1;
        check("d1234_disp", 64'({mant_a, exp_a}), 64'h122);
        pulses(8765, 1'b0); #1;
        check("d9999_cnt_b", 64'(cnt_b), 64'h9999);
        check("d9999_disp_a", 64'({mant_a, exp_a}), 64'h992);

        pulses(1, 1'b0); #1;
        check("wrap_cnt_b", 64'(cnt_b), 64'h0);
        check("wrap_disp_b", 64'({mant_b, exp_b}), 64'h000);
        check("wrap_ovf_b", 64'(ovf_b), 64'h1);
        check("sat_cnt_c", 64'(cnt_c), 64'h9999);
        pulses(5, 1'b0); #1;
        check("wrap5_disp_b", 64'({mant_b, exp_b}), 64'h050);
        check("wrap5_ovf_b", 64'(ovf_b), 64'h1);
        check("sat_disp_c", 64'({mant_c, exp_c}), 64'h992);
        step(1'b0, 1'b1, 1'b0, 1'b0); #1;
        check("clr_cnt_c", 64'(cnt_c), 64'h0);
        check("clr_ovf_c", 64'(ovf_c), 64'h0);
        check("clr_disp_c", 64'({mant_c, exp_c}), 64'h992);
        pulses(1, 1'b0); #1;
        check("clr_en_disp_c", 64'({mant_c, exp_c}), 64'h010);

        step(1'b1, 1'b0, 1'b0, 1'b0);
        pulses(57, 1'b0);
        pulses(50, 1'b1); #1;
        check("frz_cnt", 64'(cnt_a), 64'h107);
        check("frz_disp", 64'({mant_a, exp_a}), 64'h570);
        step(1'b0, 1'b0, 1'b0, 1'b0); #1;
        check("frz_rel_disp", 64'({mant_a, exp_a}), 64'h570);
        pulses(1, 1'b0); #1;
        check("frz_en_disp", 64'({mant_a, exp_a}), 64'h101);

        step(1'b1, 1'b0, 1'b0, 1'b0);
        pulses(42, 1'b0);
        step(1'b0, 1'b1, 1'b1, 1'b0); #1;
        check("clren_cnt", 64'(cnt_a), 64'h0);
        check("clren_disp", 64'({mant_a, exp_a}), 64'h420);
        step(1'b1, 1'b0, 1'b1, 1'b0); #1;
        check("rsten_cnt", 64'(cnt_a), 64'h0);
        check("rsten_disp", 64'({mant_a, exp_a}), 64'h000);
        check("rsten_ovf", 64'(ovf_a), 64'h0);

        for (int i = 0; i < 3000; i++) begin
            step(1'($urandom_range(0, 99) == 0), 1'($urandom_range(0, 49) == 0),
                 1'($urandom_range(0, 9) < 7), 1'($urandom_range(0, 4) == 0));
        end

        @(negedge clk);
        @(negedge clk);
        check("sb_drain", 64'(sb_q.size()), 64'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
